seq_alu_unit: RTL and testbench
===============================

Name: seq_alu_unit

Overview:
- Execution-side consumer of the 4-bit ALUControl code produced by the CPU's ALU decoder, implemented as a handshaked, multi-cycle ALU.
- Single-cycle ops (add/sub/logic/compare) complete in 1 cycle. Shifts iterate 1 bit per cycle.
- Intended for the multi-cycle/area-reduced CPU variant, where a barrel shifter is too costly.

Parameters:
- WIDTH, 32, datapath width in bits. Shift amount width SHW = $clog2(WIDTH), derived and not overridable.

Ports:
- clk  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous abort of the in-flight operation.
- in_valid  input  1  operation request.
- in_ready  output  1  unit can accept a request.
- alu_ctrl  input  4  ALUControl code (see encodings).
- src_a  input  WIDTH  operand A.
- src_b  input  WIDTH  operand B; shifts use src_b[SHW-1:0].
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  registered result.
- zero  output  1  registered (result == 0).
- illegal  output  1  registered; set when alu_ctrl is an unused code.

Behaviour:
- Encodings:
  - 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor.
  - 0101 slt (signed), 0111 sltu (unsigned).
  - 0110 sll, 1000 sra, 1001 srl.
  - All other codes are illegal.
- Reset (reset_n low, asynchronous):
  - State goes to IDLE.
  - in_ready=1, out_valid=0, result=0, zero=0, illegal=0, shift counter=0.
  - Reset mid-operation discards the operation. No output is produced.
- FSM states: IDLE, SHIFT, DONE.
  - in_ready = (state==IDLE). No overlap of operations.
- IDLE, accept when in_valid && in_ready (cycle T):
  - Non-shift or illegal op: compute combinationally, register result/zero/illegal, go to DONE. out_valid is high at T+1.
  - Shift with shamt=0: result=src_a, go to DONE. out_valid at T+1.
  - Shift with shamt=n>0: load the working register with src_a and the counter with n, go to SHIFT.
- SHIFT:
  - Each cycle, shift the working register by 1 and decrement the counter.
  - sll fills with 0. srl fills with 0. sra fills with the sign bit.
  - When the counter reaches 0, go to DONE. out_valid is first high at T+1+n, so the maximum latency is WIDTH cycles.
- DONE:
  - out_valid=1. result, zero and illegal are held stable while out_ready=0.
  - On out_ready, go to IDLE. in_ready returns high the next cycle, so back-to-back throughput is one op per (latency+1) cycles.
- Arithmetic rules:
  - add/sub wrap modulo 2^WIDTH.
  - slt/sltu produce {WIDTH-1 zeros, bit}.
  - Illegal op: result=0, zero=1, illegal=1, still completes in 1 cycle with the normal handshake.
- flush:
  - Sampled each cycle, with priority over all other transitions. Forces IDLE and out_valid=0.
  - result/zero/illegal keep their last values and must not be used.
  - flush in the same cycle as an accept: the request is dropped, not accepted.
- in_valid while not in_ready: ignored. Inputs are sampled only on the accept cycle; operand changes afterwards have no effect.
- No X may propagate to any output after reset, including for illegal codes.

Decomposition:
- Shared package alu_pkg:
  - ALUControl localparams (ALU_ADD…ALU_SRL), also to be used by the decoder.
  - FSM state encoding.
  - helper is_shift(ctrl).
- One sub-module, alu_comb_core: purely combinational single-cycle ops (add, sub, and, or, xor, slt, sltu, illegal→0).
- Sequencing and shifting stay in seq_alu_unit.

Test Plan:
- Reset: hold reset_n=0 mid-SHIFT (sll by 20), release → IDLE, out_valid=0, result=0, in_ready=1.
- Arithmetic: add 0xFFFFFFFF+1 → result 0x00000000, zero=1, out_valid at T+1. sub 5−7 → 0xFFFFFFFE. slt(−1,1)=1. sltu(0xFFFFFFFF,1)=0.
- Shifts:
  - sra 0x80000000 by 4 → 0xF8000000, out_valid at T+5.
  - srl same → 0x08000000.
  - sll 1 by 31 → 0x80000000 at T+32.
  - shamt 0 → src_a at T+1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → result stable, in_ready=0, new in_valid ignored. Then out_ready=1 → IDLE, next accept honoured.
- Flush: assert flush during sll by 16 at cycle T+3 → IDLE next cycle, out_valid never asserts. A following add 2+3 returns 5.
- Illegal: alu_ctrl=1111 → result 0, zero=1, illegal=1 at T+1. A subsequent legal op clears illegal.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALUControl encodings, FSM state encoding and opcode helpers for the
// sequential ALU and the decoder that drives it.
package alu_pkg;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SLT  = 4'b0101;
   localparam logic [3:0] ALU_SLL  = 4'b0110;
   localparam logic [3:0] ALU_SLTU = 4'b0111;
   localparam logic [3:0] ALU_SRA  = 4'b1000;
   localparam logic [3:0] ALU_SRL  = 4'b1001;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } alu_state_t;

   function automatic logic is_shift(input logic [3:0] ctrl);
      return (ctrl == ALU_SLL) || (ctrl == ALU_SRA) || (ctrl == ALU_SRL);
   endfunction

   function automatic logic is_legal(input logic [3:0] ctrl);
      return (ctrl == ALU_ADD)  || (ctrl == ALU_SUB)  || (ctrl == ALU_AND) ||
             (ctrl == ALU_OR)   || (ctrl == ALU_XOR)  || (ctrl == ALU_SLT) ||
             (ctrl == ALU_SLTU) || is_shift(ctrl);
   endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Purely combinational single-cycle ALU operations. Shift and unused codes
// yield zero; shifts are sequenced by the enclosing unit.
module alu_comb_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [3:0]       alu_ctrl,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic [WIDTH-1:0] y
);

   logic signed [WIDTH-1:0] sa;
   logic signed [WIDTH-1:0] sb;

   assign sa = src_a;
   assign sb = src_b;

   // Select the single-cycle result for the requested operation
   always_comb begin
      y = '0;
      case (alu_ctrl)
         ALU_ADD:  y = src_a + src_b;
         ALU_SUB:  y = src_a - src_b;
         ALU_AND:  y = src_a & src_b;
         ALU_OR:   y = src_a | src_b;
         ALU_XOR:  y = src_a ^ src_b;
         ALU_SLT:  y = {{(WIDTH-1){1'b0}}, (sa < sb)};
         ALU_SLTU: y = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
         default:  y = '0;
      endcase
   end

endmodule

// File: rtl/seq_alu_unit.sv
// Handshaked multi-cycle ALU: single-cycle ops finish in one cycle, shifts
// walk one bit per cycle so no barrel shifter is needed.
module seq_alu_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       alu_ctrl,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             illegal
);

   localparam int SHW = $clog2(WIDTH);

   alu_state_t       state;
   logic [SHW-1:0]   cnt;
   logic [3:0]       op_r;
   logic [WIDTH-1:0] comb_y;
   logic [WIDTH-1:0] shifted;
   logic [SHW-1:0]   shamt;

   assign shamt     = src_b[SHW-1:0];
   assign in_ready  = (state == ST_IDLE);
   assign out_valid = (state == ST_DONE);

   alu_comb_core #(.WIDTH(WIDTH)) u_core (
      .alu_ctrl (alu_ctrl),
      .src_a    (src_a),
      .src_b    (src_b),
      .y        (comb_y)
   );

   // One-bit step of the working register (result doubles as the shifter)
   always_comb begin
      shifted = result;
      case (op_r)
         ALU_SLL: shifted = {result[WIDTH-2:0], 1'b0};
         ALU_SRA: shifted = {result[WIDTH-1], result[WIDTH-1:1]};
         default: shifted = {1'b0, result[WIDTH-1:1]};
      endcase
   end

   // Sequencer: accept, iterate shifts, hold result until consumed
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         op_r    <= ALU_ADD;
         result  <= '0;
         zero    <= 1'b0;
         illegal <= 1'b0;
      end else if (flush) begin
         // Abort wins over everything; outputs keep stale values
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  op_r <= alu_ctrl;
                  if (is_shift(alu_ctrl)) begin
                     result  <= src_a;
                     illegal <= 1'b0;
                     if (shamt != '0) begin
                        cnt   <= shamt;
                        state <= ST_SHIFT;
                     end else begin
                        zero  <= (src_a == '0);
                        state <= ST_DONE;
                     end
                  end else begin
                     result  <= comb_y;
                     zero    <= (comb_y == '0);
                     illegal <= !is_legal(alu_ctrl);
                     state   <= ST_DONE;
                  end
               end
            end
            ST_SHIFT: begin
               result <= shifted;
               cnt    <= cnt - SHW'(1);
               if (cnt == SHW'(1)) begin
                  zero  <= (shifted == '0);
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_alu_unit.sv
// Self-checking bench for seq_alu_unit: scoreboard of expected results from a
// behavioural model, compared when the unit raises out_valid.
module tb_seq_alu_unit;

   localparam int WIDTH = 32;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       alu_ctrl;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             illegal;

   typedef struct {
      logic [31:0] r;
      logic        z;
      logic        il;
      int          lat;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   logic [3:0]  ar_c [0:8] = '{4'b0000, 4'b0001, 4'b0101, 4'b0111, 4'b0010,
                               4'b0011, 4'b0100, 4'b0101, 4'b0111};
   logic [31:0] ar_a [0:8] = '{32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF,
                               32'hF0F0F0F0, 32'h0F0F0000, 32'hA5A5A5A5,
                               32'd1, 32'd1};
   logic [31:0] ar_b [0:8] = '{32'd1, 32'd7, 32'd1, 32'd1, 32'hFF00FF00,
                               32'h0000F0F0, 32'hA5A5A5A5, 32'hFFFFFFFF,
                               32'hFFFFFFFF};

   logic [3:0]  sh_c [0:6] = '{4'b1000, 4'b1001, 4'b0110, 4'b0110, 4'b1000,
                               4'b1001, 4'b1000};
   logic [31:0] sh_a [0:6] = '{32'h80000000, 32'h80000000, 32'd1, 32'h12345678,
                               32'h7FFFFFF0, 32'hFFFFFFFF, 32'h80000001};
   logic [31:0] sh_b [0:6] = '{32'd4, 32'd4, 32'd31, 32'd0, 32'd3, 32'd31,
                               32'hFFFFFFE1};

   always #5 clk = ~clk;

   seq_alu_unit #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_ctrl  (alu_ctrl),
      .src_a     (src_a),
      .src_b     (src_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .illegal   (illegal)
   );

   function automatic exp_t model(input logic [3:0] c, input logic [31:0] a,
                                  input logic [31:0] b);
      exp_t e;
      int   sh;
      sh    = int'(b[4:0]);
      e.lat = 1;
      e.il  = 1'b0;
      case (c)
         4'b0000: e.r = a + b;
         4'b0001: e.r = a - b;
         4'b0010: e.r = a & b;
         4'b0011: e.r = a | b;
         4'b0100: e.r = a ^ b;
         4'b0101: e.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'b0111: e.r = (a < b) ? 32'd1 : 32'd0;
         4'b0110: begin e.r = a << sh;           e.lat = 1 + sh; end
         4'b1000: begin e.r = $signed(a) >>> sh; e.lat = 1 + sh; end
         4'b1001: begin e.r = a >> sh;           e.lat = 1 + sh; end
         default: begin e.r = 32'd0; e.il = 1'b1; end
      endcase
      e.z = (e.r == 32'd0);
      return e;
   endfunction

   // Issue one request (assumes in_ready) and wait, bounded, for out_valid
   task automatic run_op(input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] r,
                         output logic z, output logic il, output int lat);
      alu_ctrl = c;
      src_a    = a;
      src_b    = b;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      src_a    = $urandom;
      src_b    = $urandom;
      alu_ctrl = 4'($urandom);
      lat = 1;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      r  = result;
      z  = zero;
      il = illegal;
   endtask

   task automatic consume();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      bit seen;
      reset_n = 1'b0;
      #12;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset in_ready: got %b want 1", in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
      n_cmp++; if (result !== 32'd0) begin n_bad++; $display("FAIL reset result: got %h want 0", result); end
      n_cmp++; if ({zero, illegal} !== 2'b00) begin n_bad++; $display("FAIL reset zero/illegal: got %b want 00", {zero, illegal}); end
      #3 reset_n = 1'b1;
      @(posedge clk); #1;
      // Reset in the middle of a long shift
      alu_ctrl = 4'b0110; src_a = 32'd1; src_b = 32'd20; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (5) begin @(posedge clk); #1; end
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL mid_shift busy: got in_ready %b want 0", in_ready); end
      #2 reset_n = 1'b0;
      #1;
      n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_reset state: got in_ready %b out_valid %b want 1 0", in_ready, out_valid); end
      n_cmp++; if (result !== 32'd0) begin n_bad++; $display("FAIL mid_reset result: got %h want 0", result); end
      repeat (2) @(posedge clk);
      #3 reset_n = 1'b1;
      seen = 1'b0;
      repeat (30) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
      n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL mid_reset no_output: got out_valid seen %b want 0", seen); end
   endtask

   task automatic test_arith();
      exp_t e; logic [31:0] r; logic z, il; int lat;
      for (int i = 0; i < 9; i++) begin
         exp_q.push_back(model(ar_c[i], ar_a[i], ar_b[i]));
         run_op(ar_c[i], ar_a[i], ar_b[i], r, z, il, lat);
         e = exp_q.pop_front();
         n_cmp++; if (r !== e.r) begin n_bad++; $display("FAIL arith[%0d] result: got %h want %h", i, r, e.r); end
         n_cmp++; if (z !== e.z || il !== e.il) begin n_bad++; $display("FAIL arith[%0d] flags: got z%b il%b want z%b il%b", i, z, il, e.z, e.il); end
         n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL arith[%0d] latency: got %0d want %0d", i, lat, e.lat); end
         consume();
      end
   endtask

   task automatic test_shift();
      exp_t e; logic [31:0] r; logic z, il; int lat;
      for (int i = 0; i < 7; i++) begin
         exp_q.push_back(model(sh_c[i], sh_a[i], sh_b[i]));
         run_op(sh_c[i], sh_a[i], sh_b[i], r, z, il, lat);
         e = exp_q.pop_front();
         n_cmp++; if (r !== e.r) begin n_bad++; $display("FAIL shift[%0d] result: got %h want %h", i, r, e.r); end
         n_cmp++; if (z !== e.z || il !== e.il) begin n_bad++; $display("FAIL shift[%0d] flags: got z%b il%b want z%b il%b", i, z, il, e.z, e.il); end
         n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL shift[%0d] latency: got %0d want %0d", i, lat, e.lat); end
         consume();
      end
   endtask

   task automatic test_backpressure();
      exp_t e; logic [31:0] r; logic z, il; int lat;
      exp_q.push_back(model(4'b0000, 32'd10, 32'd20));
      run_op(4'b0000, 32'd10, 32'd20, r, z, il, lat);
      e = exp_q.pop_front();
      for (int i = 0; i < 10; i++) begin
         alu_ctrl = 4'b0001; src_a = 32'd99 + i; src_b = 32'd1; in_valid = 1'b1;
         @(posedge clk); #1;
         n_cmp++; if (result !== e.r || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_bad++; $display("FAIL hold[%0d]: got result %h ov %b ir %b want %h 1 0", i, result, out_valid, in_ready, e.r);
         end
      end
      in_valid = 1'b0;
      consume();
      n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_bad++; $display("FAIL release: got ir %b ov %b want 1 0", in_ready, out_valid); end
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ignored_req: got out_valid %b want 0", out_valid); end
      exp_q.push_back(model(4'b0100, 32'h0000FFFF, 32'h00FF00FF));
      run_op(4'b0100, 32'h0000FFFF, 32'h00FF00FF, r, z, il, lat);
      e = exp_q.pop_front();
      n_cmp++; if (r !== e.r || lat !== e.lat) begin n_bad++; $display("FAIL after_release: got %h lat %0d want %h lat %0d", r, lat, e.r, e.lat); end
      consume();
   endtask

   task automatic test_flush();
      exp_t e; logic [31:0] r; logic z, il; int lat; bit seen;
      alu_ctrl = 4'b0110; src_a = 32'd1; src_b = 32'd16; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_shift: got ir %b ov %b want 1 0", in_ready, out_valid); end
      seen = 1'b0;
      repeat (20) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
      n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL flush_no_output: got seen %b want 0", seen); end
      exp_q.push_back(model(4'b0000, 32'd2, 32'd3));
      run_op(4'b0000, 32'd2, 32'd3, r, z, il, lat);
      e = exp_q.pop_front();
      n_cmp++; if (r !== e.r || lat !== e.lat) begin n_bad++; $display("FAIL post_flush_add: got %h lat %0d want %h lat %0d", r, lat, e.r, e.lat); end
      // Flush while holding a result
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_done: got ir %b ov %b want 1 0", in_ready, out_valid); end
      // Flush coinciding with a request drops the request
      alu_ctrl = 4'b0000; src_a = 32'd7; src_b = 32'd8; in_valid = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      seen = 1'b0;
      repeat (3) begin if (out_valid || !in_ready) seen = 1'b1; @(posedge clk); #1; end
      n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL flush_accept_drop: got accepted %b want 0", seen); end
   endtask

   task automatic test_illegal();
      exp_t e; logic [31:0] r; logic z, il; int lat;
      logic [3:0] codes [0:3];
      codes = '{4'b1111, 4'b1010, 4'b1100, 4'b0000};
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(model(codes[i], 32'hDEADBEEF, 32'h00000004));
         run_op(codes[i], 32'hDEADBEEF, 32'h00000004, r, z, il, lat);
         e = exp_q.pop_front();
         n_cmp++; if (r !== e.r || z !== e.z) begin n_bad++; $display("FAIL illegal[%0d] result: got %h z%b want %h z%b", i, r, z, e.r, e.z); end
         n_cmp++; if (il !== e.il || lat !== e.lat) begin n_bad++; $display("FAIL illegal[%0d] flag: got il%b lat %0d want il%b lat %0d", i, il, lat, e.il, e.lat); end
         consume();
      end
   endtask

   task automatic test_back_to_back();
      exp_t e; logic [31:0] r, a, b; logic z, il; int lat; logic [3:0] c;
      for (int i = 0; i < 16; i++) begin
         c = 4'($urandom_range(0, 15));
         a = $urandom;
         b = $urandom;
         if (i % 4 == 0) a = 32'd0;
         exp_q.push_back(model(c, a, b));
         run_op(c, a, b, r, z, il, lat);
         e = exp_q.pop_front();
         n_cmp++; if (r !== e.r || z !== e.z || il !== e.il) begin
            n_bad++; $display("FAIL b2b[%0d] op %b: got %h z%b il%b want %h z%b il%b", i, c, r, z, il, e.r, e.z, e.il);
         end
         n_cmp++; if (lat !== e.lat) begin n_bad++; $display("FAIL b2b[%0d] latency: got %0d want %0d", i, lat, e.lat); end
         consume();
         n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b[%0d] in_ready: got %b want 1", i, in_ready); end
      end
   endtask

   initial begin
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      alu_ctrl  = 4'b0000;
      src_a     = '0;
      src_b     = '0;
      test_reset();
      test_arith();
      test_shift();
      test_backpressure();
      test_flush();
      test_illegal();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
